adpcm_tdm_tx: RTL

- Serial TDM transmitter for the multichannel ADPCM codec; the far-end counterpart of the TDM code receiver.
- Accepts per-channel G.726 codewords (I) from the encoder datapath and double-buffers one frame of codes.
- Shifts each frame out MSB-first on a single serial line with a frame-sync pulse.
- Sits between the encoder output stage and the line interface.

---
 rtl/adpcm_tdm_pkg.sv | 21 ++
 rtl/tdm_bit_timer.sv | 57 +++++
 rtl/adpcm_tdm_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/adpcm_tdm_pkg.sv
// Shared types and defaults for the ADPCM TDM transmit path.
package adpcm_tdm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tx_state_t;

    localparam int DEF_NUM_CH  = 32;
    localparam int DEF_CODE_W  = 4;
    localparam int DEF_SLOT_W  = 8;
    localparam int DEF_CLK_DIV = 4;
    localparam logic [DEF_CODE_W-1:0] DEF_IDLE_CODE = 4'b1111;

    // Counter width for n states; never returns zero so single-entry counters still exist.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_bit_timer.sv
// Serial bit-rate divider plus slot/bit position counters for the TDM frame.
module tdm_bit_timer
    import adpcm_tdm_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int SLOT_W  = DEF_SLOT_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    active,
    input  logic                    step,
    output logic                    tick,
    output logic                    first_bit,
    output logic                    last_bit,
    output logic [ch_w(NUM_CH)-1:0] slot,
    output logic [ch_w(SLOT_W)-1:0] bit_idx
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int BIT_W = ch_w(SLOT_W);
    localparam int DIV_W = ch_w(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CH_W-1:0]  SLOT_LAST = CH_W'(NUM_CH - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(SLOT_W - 1);

    logic [DIV_W-1:0] div;

    assign tick      = active && (div == DIV_LAST);
    assign first_bit = (slot == '0) && (bit_idx == '0);
    assign last_bit  = (slot == SLOT_LAST) && (bit_idx == BIT_LAST);

    // start preloads the divider so the very next clk is a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= '0;
            slot    <= '0;
            bit_idx <= '0;
        end else if (start) begin
            div     <= DIV_LAST;
            slot    <= '0;
            bit_idx <= '0;
        end else if (active) begin
            div <= tick ? '0 : div + 1'b1;
            if (tick && step) begin
                if (bit_idx == BIT_LAST) begin
                    bit_idx <= '0;
                    slot    <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
                end else begin
                    bit_idx <= bit_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adpcm_tdm_tx.sv
// Multichannel ADPCM TDM transmitter: double-buffered code banks, frame swap
// with idle-code substitution, and an MSB-first serializer with frame sync.
module adpcm_tdm_tx
    import adpcm_tdm_pkg::*;
#(
    parameter int                NUM_CH    = DEF_NUM_CH,
    parameter int                CODE_W    = DEF_CODE_W,
    parameter int                SLOT_W    = DEF_SLOT_W,
    parameter int                CLK_DIV   = DEF_CLK_DIV,
    parameter logic [CODE_W-1:0] IDLE_CODE = CODE_W'(DEF_IDLE_CODE)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ch_w(NUM_CH)-1:0] in_ch,
    input  logic [CODE_W-1:0]       in_code,
    output logic                    sdo,
    output logic                    fs,
    output logic                    frame_start,
    output logic                    underrun,
    input  logic                    underrun_clr,
    input  logic                    scan_in0,
    input  logic                    scan_in1,
    input  logic                    scan_in2,
    input  logic                    scan_in3,
    input  logic                    scan_in4,
    input  logic                    scan_enable,
    input  logic                    test_mode,
    output logic                    scan_out0,
    output logic                    scan_out1,
    output logic                    scan_out2,
    output logic                    scan_out3,
    output logic                    scan_out4,
    output tx_state_t               state
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int BIT_W = ch_w(SLOT_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_W - 1);

    tx_state_t                   state_next;
    logic                        tick, first_bit, last_bit;
    logic [CH_W-1:0]             slot;
    logic [BIT_W-1:0]            bit_idx;
    logic                        emit, clear_line, swap, any_missing, wr_accept, tx_bit;
    logic [NUM_CH-1:0][CODE_W-1:0] write_bank, read_bank, fresh_bank;
    logic [NUM_CH-1:0]           written;
    logic [CODE_W-1:0]           cur_code;
    logic [SLOT_W-1:0]           slot_word;
    logic                        unused_dft;

    tdm_bit_timer #(
        .NUM_CH  (NUM_CH),
        .SLOT_W  (SLOT_W),
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .start     ((state == IDLE) && enable),
        .active    (state != IDLE),
        .step      (state == RUN),
        .tick      (tick),
        .first_bit (first_bit),
        .last_bit  (last_bit),
        .slot      (slot),
        .bit_idx   (bit_idx)
    );

    // Handshake: a code is taken on any clk with in_valid & in_ready; there is
    // no backpressure beyond enable/reset, and out-of-range channels are dropped.
    assign in_ready  = enable & ~reset;
    assign wr_accept = in_valid && in_ready && ({1'b0, in_ch} < (CH_W + 1)'(NUM_CH));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        clear_line = 1'b0;
        case (state)
            IDLE: begin
                clear_line = 1'b1;
                if (enable) state_next = RUN;
            end
            RUN: begin
                if (tick) begin
                    emit = 1'b1;
                    if (last_bit && !enable) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (tick) begin
                    clear_line = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign swap        = emit && first_bit;
    assign frame_start = swap;

    // Contents the read bank takes on at the swap: unwritten channels go idle.
    always_comb begin
        any_missing = 1'b0;
        fresh_bank  = write_bank;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!written[ch]) begin
                fresh_bank[ch] = IDLE_CODE;
                any_missing    = 1'b1;
            end
        end
    end

    // Slot 0 bit 0 goes out on the swap tick itself, so it must come from the incoming bank.
    assign cur_code  = first_bit ? fresh_bank[0] : read_bank[slot];
    assign slot_word = SLOT_W'(cur_code) << (SLOT_W - CODE_W);
    assign tx_bit    = slot_word[BIT_LAST - bit_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            write_bank <= {NUM_CH{IDLE_CODE}};
            read_bank  <= {NUM_CH{IDLE_CODE}};
            written    <= '0;
            underrun   <= 1'b0;
        end else begin
            if (swap) begin
                read_bank <= fresh_bank;
                written   <= '0;
            end
            if (wr_accept) begin
                write_bank[in_ch] <= in_code;
                written[in_ch]    <= 1'b1;
            end
            if (swap && any_missing) underrun <= 1'b1;
            else if (underrun_clr)   underrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sdo <= 1'b0;
            fs  <= 1'b0;
        end else if (emit) begin
            sdo <= tx_bit;
            fs  <= first_bit;
        end else if (clear_line) begin
            sdo <= 1'b0;
            fs  <= 1'b0;
        end
    end

    // DFT hooks terminate here; scan stitching is inserted downstream.
    assign unused_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode};
    assign scan_out0  = 1'b0;
    assign scan_out1  = 1'b0;
    assign scan_out2  = 1'b0;
    assign scan_out3  = 1'b0;
    assign scan_out4  = 1'b0;

endmodule
